apb_master_bridge: RTL and testbench

//  APB requester for the system bus: takes single read/write commands from a local

---
 rtl/apb_master_bridge.sv | 158 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: accepts one valid/ready command at a time and runs a single
// SETUP/ACCESS transfer, returning read data or an error on a one-cycle strobe.
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAIN_ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SEL_LSB         = 12,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [MAIN_ADDR_WIDTH-1:0] req_addr,
  input  logic                       req_write,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  input  logic [DATA_WIDTH/8-1:0]    req_strb,
  output logic                       rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic [NUM_SLAVES-1:0]      PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [MAIN_ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0]      PWDATA,
  output logic [DATA_WIDTH/8-1:0]    PSTRB,
  input  logic                       PREADY,
  input  logic [DATA_WIDTH-1:0]      PRDATA,
  input  logic                       PSLVERR
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned SelW  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CntW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDecErr} state_e;

  state_e                     state_q, state_d;
  logic [NUM_SLAVES-1:0]      psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic [MAIN_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
  logic [StrbW-1:0]           pstrb_q, pstrb_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                       rsp_err_q, rsp_err_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [SelW-1:0]            sel_idx;
  logic                       sel_ok;

  assign sel_idx   = req_addr[SEL_LSB +: SelW];
  // Non-power-of-two slave counts leave index codes with no slave behind them.
  assign sel_ok    = 32'(sel_idx) < NUM_SLAVES;
  assign req_ready = (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : '0;
          if (sel_ok) begin
            state_d   = StSetup;
            psel_d    = NUM_SLAVES'(1) << sel_idx;
            penable_d = 1'b0;
            cnt_d     = '0;
          end else begin
            state_d = StDecErr;
          end
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT_CYCLES != 0) && (cnt_d == CntW'(TIMEOUT_CYCLES))) begin
            psel_d      = '0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = StIdle;
          end
        end
      end
      StDecErr: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET_n) begin
      state_q     <= StIdle;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed steps, a response scoreboard and a small
// APB slave model with programmable wait states.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESET_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  // Second instance with three slaves for the decode-error case.
  logic        r3_valid, r3_ready, r3_write;
  logic [31:0] r3_addr, r3_wdata;
  logic [3:0]  r3_strb;
  logic        r3_rsp_valid, r3_rsp_err;
  logic [31:0] r3_rsp_rdata;
  logic [2:0]  r3_psel;
  logic        r3_penable, r3_pwrite;
  logic [31:0] r3_paddr, r3_pwdata;
  logic [3:0]  r3_pstrb;
  logic        r3_pready, r3_pslverr;
  logic [31:0] r3_prdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] sb[$];
  int          wait_n = 0;
  int          wcnt = 0;
  int          pen_cnt = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;

  apb_master_bridge dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );

  apb_master_bridge #(.NUM_SLAVES(3)) dut3 (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_addr(r3_addr),
    .req_write(r3_write), .req_wdata(r3_wdata), .req_strb(r3_strb),
    .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata), .rsp_err(r3_rsp_err),
    .PSEL(r3_psel), .PENABLE(r3_penable), .PWRITE(r3_pwrite), .PADDR(r3_paddr),
    .PWDATA(r3_pwdata), .PSTRB(r3_pstrb), .PREADY(r3_pready), .PRDATA(r3_prdata),
    .PSLVERR(r3_pslverr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: PREADY rises after wait_n low ACCESS samples.
  initial PREADY = 1'b0;
  always @(negedge PCLK) begin
    PRDATA  = slv_rdata;
    PSLVERR = slv_err;
    if ((|PSEL) && PENABLE) begin
      PREADY = (wcnt == wait_n);
      wcnt++;
      pen_cnt++;
    end else begin
      PREADY = 1'b0;
      wcnt   = 0;
    end
  end

  // Response monitor against the scoreboard.
  always @(negedge PCLK) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(e[32]));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
      end
    end
  end

  // Call just after a negedge; returns 1 unit after the accepting edge.
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic push, input logic [32:0] exp);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_strb  = s;
    chk("req_ready_before_accept", 64'(req_ready), 64'd1);
    if (push) sb.push_back(exp);
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge PCLK);
      #1;
    end
    chk("rsp_arrived", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET_n  = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_strb = '0;
    r3_valid  = 1'b0; r3_addr = '0; r3_write = 1'b0; r3_wdata = '0; r3_strb = '0;
    r3_pready = 1'b1; r3_prdata = '0; r3_pslverr = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_pstrb", 64'(PSTRB), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    @(negedge PCLK);
    PRESET_n = 1'b1;

    // Zero-wait write to slave 0; write returns rdata 0 even with PRDATA busy.
    @(negedge PCLK);
    wait_n = 0; slv_rdata = 32'hFFFF_0000; slv_err = 1'b0;
    send(32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, {1'b0, 32'h0});
    chk("w_setup_psel", 64'(PSEL), 64'b0001);
    chk("w_setup_penable", 64'(PENABLE), 64'd0);
    chk("w_setup_bus", {PWRITE, PADDR, PSTRB}, {1'b1, 32'h4, 4'hF});
    chk("w_setup_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
    chk("w_setup_ready", 64'(req_ready), 64'd0);
    @(posedge PCLK); #1;
    chk("w_access", 64'({PSEL, PENABLE}), 64'b0001_1);
    @(posedge PCLK); #1;
    chk("w_done_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("w_done_bus", 64'({PSEL, PENABLE}), 64'd0);
    chk("w_done_paddr_hold", 64'(PADDR), 64'h4);
    chk("w_done_ready", 64'(req_ready), 64'd1);
    wait_sb();
    @(posedge PCLK); #1;
    chk("rsp_valid_one_cycle", 64'(rsp_valid), 64'd0);

    // Read from slave 2 with three wait states.
    @(negedge PCLK);
    wait_n = 3; slv_rdata = 32'h1234_5678; pen_cnt = 0;
    send(32'h0000_2008, 1'b0, 32'h5555_5555, 4'hF, 1'b1, {1'b0, 32'h1234_5678});
    chk("r_psel", 64'(PSEL), 64'b0100);
    chk("r_pstrb_zero", 64'(PSTRB), 64'd0);
    wait_sb();
    chk("r_penable_cycles", 64'(pen_cnt), 64'd4);

    // Timeout with PREADY stuck low.
    @(negedge PCLK);
    wait_n = 1000; slv_rdata = 32'hCAFE_F00D; pen_cnt = 0;
    send(32'h0000_1010, 1'b0, 32'h0, 4'h0, 1'b1, {1'b1, 32'h0});
    wait_sb();
    chk("to_penable_cycles", 64'(pen_cnt), 64'd16);
    chk("to_psel_dropped", 64'(PSEL), 64'd0);

    // PREADY on the sixteenth ACCESS sample beats the timeout.
    @(negedge PCLK);
    wait_n = 15; slv_rdata = 32'h0F0F_1234; pen_cnt = 0;
    send(32'h0000_3000, 1'b0, 32'h0, 4'h0, 1'b1, {1'b0, 32'h0F0F_1234});
    chk("edge_psel", 64'(PSEL), 64'b1000);
    wait_sb();
    chk("edge_penable_cycles", 64'(pen_cnt), 64'd16);

    // Slave errors on write and read.
    @(negedge PCLK);
    wait_n = 0; slv_err = 1'b1; slv_rdata = 32'hAAAA_5555;
    send(32'h0000_1000, 1'b1, 32'h1111_2222, 4'h3, 1'b1, {1'b1, 32'h0});
    wait_sb();
    @(negedge PCLK);
    send(32'h0000_1004, 1'b0, 32'h0, 4'h0, 1'b1, {1'b1, 32'h0});
    wait_sb();
    slv_err = 1'b0;

    // Decode error on the three-slave instance, then a valid slave 2 access.
    @(negedge PCLK);
    r3_valid = 1'b1; r3_addr = 32'h0000_3000;
    chk("dec_ready", 64'(r3_ready), 64'd1);
    @(posedge PCLK); #1;
    r3_valid = 1'b0;
    chk("dec_psel", 64'(r3_psel), 64'd0);
    chk("dec_early", 64'(r3_rsp_valid), 64'd0);
    @(posedge PCLK); #1;
    chk("dec_rsp", 64'({r3_rsp_valid, r3_rsp_err, r3_rsp_rdata}), {31'd0, 1'b1, 1'b1, 32'h0});
    chk("dec_psel_after", 64'(r3_psel), 64'd0);
    @(negedge PCLK);
    r3_valid = 1'b1; r3_addr = 32'h0000_2000;
    @(posedge PCLK); #1;
    r3_valid = 1'b0;
    chk("s3_psel2", 64'(r3_psel), 64'b100);
    repeat (3) @(posedge PCLK);

    // Reset during ACCESS: no response, then a normal read.
    @(negedge PCLK);
    wait_n = 1000;
    send(32'h0000_1000, 1'b0, 32'h0, 4'h0, 1'b0, 33'h0);
    @(posedge PCLK); #1;
    chk("mid_access", 64'(PENABLE), 64'd1);
    @(negedge PCLK);
    PRESET_n = 1'b0;
    @(posedge PCLK); #1;
    chk("mid_rst_bus", 64'({PSEL, PENABLE, PWRITE, PSTRB}), 64'd0);
    chk("mid_rst_addr_data", {PADDR, PWDATA}, 64'd0);
    chk("mid_rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    @(negedge PCLK);
    PRESET_n = 1'b1;
    repeat (3) @(negedge PCLK);
    wait_n = 0; slv_rdata = 32'h0BAD_F00D;
    send(32'h0000_1004, 1'b0, 32'h0, 4'h0, 1'b1, {1'b0, 32'h0BAD_F00D});
    wait_sb();

    repeat (3) @(posedge PCLK);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
